// File: rtl/alu_stream_pipe_if.sv
// Command/result stream bundle for alu_stream_pipe: valid/ready on both sides
// plus occupancy counts for each FIFO.
interface alu_stream_pipe_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
);
    localparam int RES_W = 2 * DATA_W + 1;
    localparam int CMD_W = 2 * DATA_W + 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [CMD_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic             out_err;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, in_count, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, in_count, out_count
    );
endinterface

// File: rtl/alu_stream_pipe.sv
// Streaming ALU: command FIFO -> multi-cycle add/sub/mul/div engine -> result FIFO.
// Results leave in command order; divide-by-zero is flagged alongside the result.

module alu_stream_pipe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       not_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags are registered copies of the count, so a same-cycle pop never frees a slot early.
    assign push_ok = push && !full;
    assign pop_ok  = pop && not_empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_d;
            full      <= (count_d == CNT_W'(DEPTH));
            not_empty <= (count_d != '0);
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are unreachable once the count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module alu_stream_pipe #(
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 8,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_stream_pipe_if.slave  bus
);
    localparam int RES_W   = 2 * DATA_W + 1;
    localparam int CMD_W   = 2 * DATA_W + 2;
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [CMD_W-1:0] cmd_data;
    logic             cmd_full;
    logic             cmd_not_empty;
    logic             cmd_pop;

    logic [RES_W:0]   res_rdata;
    logic             res_full;
    logic             res_not_empty;
    logic             res_push;
    logic [RES_W-1:0] res_val;
    logic             res_err;

    state_t           state_q;
    state_t           state_d;
    logic [CYC_W-1:0] cnt_q;
    logic [CYC_W-1:0] cnt_d;
    logic [CYC_W-1:0] cnt_load;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    op_t               op_q;

    alu_stream_pipe_fifo #(.W(CMD_W), .DEPTH(DEPTH)) cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.in_valid),
        .wdata     (bus.in_data),
        .pop       (cmd_pop),
        .rdata     (cmd_data),
        .count     (bus.in_count),
        .full      (cmd_full),
        .not_empty (cmd_not_empty)
    );

    alu_stream_pipe_fifo #(.W(RES_W + 1), .DEPTH(DEPTH)) res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (res_push),
        .wdata     ({res_err, res_val}),
        .pop       (bus.out_ready),
        .rdata     (res_rdata),
        .count     (bus.out_count),
        .full      (res_full),
        .not_empty (res_not_empty)
    );

    assign bus.in_ready  = !cmd_full;
    assign bus.out_valid = res_not_empty;
    // Head is masked while empty so the port reads zero after reset rather than stale storage.
    assign bus.out_data  = res_not_empty ? res_rdata[RES_W-1:0] : '0;
    assign bus.out_err   = res_not_empty & res_rdata[RES_W];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_pop) {op_q, b_q, a_q} <= cmd_data;
    end

    // FSM outputs: a result leaves only when the registered full flag says there is room.
    always_comb begin
        res_push = (state_q == BUSY) && (cnt_q == '0) && !res_full;
        cmd_pop  = cmd_not_empty && ((state_q == IDLE) || res_push);
        case (op_t'(cmd_data[CMD_W-1 -: 2]))
            OP_MUL:  cnt_load = CYC_W'(MUL_CYCLES - 1);
            OP_DIV:  cnt_load = CYC_W'(DIV_CYCLES - 1);
            default: cnt_load = '0;
        endcase
    end

    // FSM next state: popping reloads the counter even on the cycle a result is pushed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cmd_pop) begin
            state_d = BUSY;
            cnt_d   = cnt_load;
        end else if (res_push) begin
            state_d = IDLE;
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CYC_W'(1);
        end
    end

    // The operands are held for the whole BUSY period, so the arithmetic is a plain multicycle path.
    always_comb begin
        res_val = '0;
        res_err = 1'b0;
        case (op_q)
            OP_ADD: res_val = RES_W'(a_q) + RES_W'(b_q);
            OP_SUB: res_val = RES_W'(a_q) - RES_W'(b_q);
            OP_MUL: res_val = RES_W'(a_q) * RES_W'(b_q);
            OP_DIV: begin
                if (b_q == '0) begin
                    res_val = '1;
                    res_err = 1'b1;
                end else begin
                    res_val = RES_W'(a_q / b_q);
                end
            end
            default: res_val = '0;
        endcase
    end
endmodule
